// File: rtl/pcm_to_i2s.sv
// pcm_to_i2s: serialises left/right PCM sample pairs onto an I2S bus (sck, ws, sd), MSB first.
// Latency: a pair accepted before a frame boundary starts shifting out in slot 0 of that frame.
// Backpressure: one holding register; in_ready is low while it is occupied.
// Option: define PCM_TO_I2S_HOLD_LAST_EN to repeat the last pair on underrun (default: zeros).
module pcm_to_i2s #(
  parameter int NUMBER_OF_BITS = 8,
  parameter int CLK_DIV        = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [NUMBER_OF_BITS-1:0] in_left,
  input  logic [NUMBER_OF_BITS-1:0] in_right,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      sck,
  output logic                      ws,
  output logic                      sd,
  output logic                      underrun
);

  localparam int N  = NUMBER_OF_BITS;
  localparam int FW = 2 * N;
  localparam int SW = (FW > 1) ? $clog2(FW) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [SW-1:0] LAST_SLOT = SW'(FW - 1);
  localparam logic [SW-1:0] WS_FIRST  = SW'(N - 1);
  localparam logic [SW-1:0] WS_LAST   = SW'(FW - 2);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [SW-1:0] slot;
  logic [SW-1:0] slot_nxt;
  logic [FW-1:0] shreg;
  logic [FW-1:0] hold_dat;
  logic          hold_full;
  logic [FW-1:0] fill_dat;
  logic [FW-1:0] load_dat;
  logic          load_ur;
  logic          div_wrap;
  logic          fall;
  logic          frame_start;

  assign in_ready = ~hold_full;

  // Decode the sck falling edge, next slot, and which pair starts the next frame.
  always_comb begin
    div_wrap    = (div_cnt == DIV_LAST);
    fall        = ena && div_wrap && sck;
    slot_nxt    = (slot == LAST_SLOT) ? '0 : slot + 1'b1;
    frame_start = fall && (slot == LAST_SLOT);
    load_ur     = 1'b0;
    load_dat    = fill_dat;
    if (hold_full) begin
      load_dat = hold_dat;
    end else if (in_valid) begin
      load_dat = {in_left, in_right};
    end else begin
      load_ur = 1'b1;
    end
  end

`ifdef PCM_TO_I2S_HOLD_LAST_EN
  logic [FW-1:0] last_dat;

  // Remember the pair most recently loaded so an underrun frame can repeat it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dat <= '0;
    end else if (frame_start) begin
      last_dat <= load_dat;
    end
  end

  assign fill_dat = last_dat;
`else
  assign fill_dat = '0;
`endif

  // Bit-clock divider: sck toggles every CLK_DIV clk cycles; held low while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!ena) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Slot counter, ws, sd and the shift register advance only on sck falling edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot     <= LAST_SLOT;
      ws       <= 1'b0;
      sd       <= 1'b0;
      shreg    <= '0;
      underrun <= 1'b0;
    end else if (!ena) begin
      slot     <= LAST_SLOT;
      ws       <= 1'b0;
      sd       <= 1'b0;
      shreg    <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= frame_start && load_ur;
      if (fall) begin
        slot <= slot_nxt;
        ws   <= (slot_nxt >= WS_FIRST) && (slot_nxt <= WS_LAST);
        if (frame_start) begin
          sd    <= load_dat[FW-1];
          shreg <= {load_dat[FW-2:0], 1'b0};
        end else begin
          sd    <= shreg[FW-1];
          shreg <= {shreg[FW-2:0], 1'b0};
        end
      end
    end
  end

  // Holding register: captures on handshake, drains into the shifter at each frame start.
  // A pair offered exactly at a frame start with the register empty bypasses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_dat  <= '0;
    end else if (frame_start && hold_full) begin
      hold_full <= 1'b0;
    end else if (in_valid && !hold_full && !frame_start) begin
      hold_full <= 1'b1;
      hold_dat  <= {in_left, in_right};
    end
  end

endmodule

// File: tb/tb_pcm_to_i2s.sv
module tb_pcm_to_i2s;

  localparam int N  = 8;
  localparam int CD = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b0;
  logic [N-1:0] in_left = '0;
  logic [N-1:0] in_right = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         sck;
  logic         ws;
  logic         sd;
  logic         underrun;

  pcm_to_i2s #(.NUMBER_OF_BITS(N), .CLK_DIV(CD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .in_left  (in_left),
    .in_right (in_right),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sck      (sck),
    .ws       (ws),
    .sd       (sd),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard state
  logic [2*N-1:0] exp_q[$];
  logic [2*N-1:0] last_pair = '0;
  logic [2*N-1:0] cur_exp = '0;
  logic [2*N-1:0] rx = '0;
  logic [2*N-1:0] last_rx = '0;
  bit             cur_vld = 0;
  bit             prev_sck = 0;
  bit             at_slot0 = 0;
  bit             exp_ur;
  bit             exp_ws;
  int             slot = 2*N-1;
  int             mon_cyc = 0;
  int             last_rise = -1;
  int             frames_done = 0;
  int             ur_t[$];

  // every accepted pair is expected on the bus, in order
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) exp_q.push_back({in_left, in_right});
  end

  // receiver model: samples ws/sd on sck rising edges, tracks slots on falling edges
  always begin
    @(posedge clk);
    #1;
    mon_cyc++;
    at_slot0 = 0;
    if (!rst_n || !ena) begin
      slot = 2*N-1;
      prev_sck = 0;
      last_rise = -1;
      cur_vld = 0;
    end else begin
      if (sck && !prev_sck) begin
        if (last_rise >= 0) begin
          n_cmp++;
          if (mon_cyc - last_rise != 2*CD) begin
            n_err++;
            $display("FAIL sck_period got %0d clk want %0d clk", mon_cyc - last_rise, 2*CD);
          end
        end
        last_rise = mon_cyc;
        exp_ws = (slot >= N-1) && (slot <= 2*N-2);
        n_cmp++;
        if (ws !== exp_ws) begin
          n_err++;
          $display("FAIL ws_slot%0d got %b want %b", slot, ws, exp_ws);
        end
        rx[2*N-1-slot] = sd;
        if (slot == 2*N-1 && cur_vld) begin
          n_cmp++;
          if (rx !== cur_exp) begin
            n_err++;
            $display("FAIL frame_data got %h want %h", rx, cur_exp);
          end
          last_rx = rx;
          frames_done++;
          cur_vld = 0;
        end
      end
      if (!sck && prev_sck) begin
        slot = (slot + 1) % (2*N);
        if (slot == 0) begin
          at_slot0 = 1;
          n_cmp++;
          if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL in_ready_at_slot0 got %b want 1", in_ready);
          end
          if (exp_q.size() > 0) begin
            cur_exp = exp_q.pop_front();
            exp_ur = 0;
          end else begin
`ifdef PCM_TO_I2S_HOLD_LAST_EN
            cur_exp = last_pair;
`else
            cur_exp = '0;
`endif
            exp_ur = 1;
          end
          last_pair = cur_exp;
          cur_vld = 1;
          n_cmp++;
          if (underrun !== exp_ur) begin
            n_err++;
            $display("FAIL underrun_at_slot0 got %b want %b", underrun, exp_ur);
          end
          if (underrun === 1'b1) ur_t.push_back(mon_cyc);
        end
      end
      if (!at_slot0) begin
        n_cmp++;
        if (underrun !== 1'b0) begin
          n_err++;
          $display("FAIL underrun_outside_slot0 got %b want 0 (slot %0d)", underrun, slot);
        end
      end
      prev_sck = sck;
    end
  end

  // drive one pair and wait for its handshake; in_valid stays high on return
  task automatic offer(input logic [N-1:0] l, input logic [N-1:0] r, output bit ok);
    @(negedge clk);
    in_left = l;
    in_right = r;
    in_valid = 1'b1;
    ok = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      ok = in_ready;
      @(posedge clk);
      #2;
      if (!ok) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ena = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (sck !== 1'b0) begin n_err++; $display("FAIL reset_sck got %b want 0", sck); end
    n_cmp++; if (ws !== 1'b0) begin n_err++; $display("FAIL reset_ws got %b want 0", ws); end
    n_cmp++; if (sd !== 1'b0) begin n_err++; $display("FAIL reset_sd got %b want 0", sd); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun got %b want 0", underrun); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    bit ok;
    int f0;
    f0 = frames_done;
    offer(8'hA5, 8'h3C, ok);
    @(negedge clk);
    in_valid = 1'b0;
    ena = 1'b1;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL basic_accept got no handshake want handshake"); end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_in_ready_full got %b want 0", in_ready); end
    for (int c = 0; c < 200 && frames_done == f0; c++) @(negedge clk);
    n_cmp++;
    if (frames_done == f0) begin
      n_err++;
      $display("FAIL basic_frame_timeout got no frame want one");
    end else if (last_rx !== 16'hA53C) begin
      n_err++;
      $display("FAIL basic_bits got %h want a53c", last_rx);
    end
  endtask

  task automatic test_underrun;
    ur_t.delete();
    for (int c = 0; c < 4*64+20 && ur_t.size() < 3; c++) @(negedge clk);
    n_cmp++;
    if (ur_t.size() < 3) begin
      n_err++;
      $display("FAIL underrun_count got %0d want 3", ur_t.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_cmp++;
        if (ur_t[i] - ur_t[i-1] != 64) begin
          n_err++;
          $display("FAIL underrun_spacing got %0d clk want 64", ur_t[i] - ur_t[i-1]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      offer(8'($urandom), 8'($urandom), ok);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL b2b_accept%0d got timeout want handshake", i);
      end else if (!at_slot0 && in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_in_ready_drop%0d got %b want 0", i, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 400 && (exp_q.size() > 0 || cur_vld); c++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() > 0 || cur_vld) begin
      n_err++;
      $display("FAIL b2b_drain got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_enable;
    bit ok1, ok2;
    int c0, f0;
    logic [N-1:0] pl, pr;
    pl = 8'h96;
    pr = 8'h0F;
    offer(8'h71, 8'hE2, ok1);
    offer(pl, pr, ok2);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (!(ok1 && ok2)) begin n_err++; $display("FAIL ena_accept got %b%b want 11", ok1, ok2); end
    for (int c = 0; c < 100 && slot != 5; c++) @(negedge clk);
    ena = 1'b0;
    @(posedge clk);
    #2;
    n_cmp++; if (sck !== 1'b0) begin n_err++; $display("FAIL ena_off_sck got %b want 0", sck); end
    n_cmp++; if (ws !== 1'b0) begin n_err++; $display("FAIL ena_off_ws got %b want 0", ws); end
    n_cmp++; if (sd !== 1'b0) begin n_err++; $display("FAIL ena_off_sd got %b want 0", sd); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ena_off_in_ready got %b want 0", in_ready); end
    repeat (10) @(negedge clk);
    ena = 1'b1;
    f0 = frames_done;
    c0 = 0;
    for (int c = 1; c <= 20 && c0 == 0; c++) begin
      @(posedge clk);
      #2;
      if (at_slot0) c0 = c;
    end
    n_cmp++;
    if (c0 != 4) begin n_err++; $display("FAIL ena_restart_latency got %0d clk want 4", c0); end
    for (int c = 0; c < 100 && frames_done == f0; c++) @(negedge clk);
    n_cmp++;
    if (last_rx !== {pl, pr}) begin n_err++; $display("FAIL ena_held_pair got %h want %h", last_rx, {pl, pr}); end
  endtask

  task automatic test_reset_mid;
    bit ok1, ok2;
    int c0;
    offer(8'h11, 8'h22, ok1);
    offer(8'h33, 8'h44, ok2);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (!(ok1 && ok2)) begin n_err++; $display("FAIL rst_mid_accept got %b%b want 11", ok1, ok2); end
    for (int c = 0; c < 100 && slot != 9; c++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    last_pair = '0;
    #1;
    n_cmp++; if (sck !== 1'b0) begin n_err++; $display("FAIL rst_mid_sck got %b want 0", sck); end
    n_cmp++; if (ws !== 1'b0) begin n_err++; $display("FAIL rst_mid_ws got %b want 0", ws); end
    n_cmp++; if (sd !== 1'b0) begin n_err++; $display("FAIL rst_mid_sd got %b want 0", sd); end
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL rst_mid_underrun got %b want 0", underrun); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    c0 = 0;
    for (int c = 1; c <= 20 && c0 == 0; c++) begin
      @(posedge clk);
      #2;
      if (at_slot0) c0 = c;
    end
    n_cmp++;
    if (c0 != 4) begin n_err++; $display("FAIL rst_release_latency got %0d clk want 4", c0); end
  endtask

  task automatic test_fill_data;
    bit ok;
    int f0;
    logic [2*N-1:0] fill;
`ifdef PCM_TO_I2S_HOLD_LAST_EN
    fill = 16'h5AC3;
`else
    fill = 16'h0000;
`endif
    f0 = frames_done;
    offer(8'h5A, 8'hC3, ok);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 200 && frames_done < f0 + 2; c++) @(negedge clk);
    n_cmp++;
    if (last_rx !== 16'h5AC3) begin n_err++; $display("FAIL fill_sent_pair got %h want 5ac3", last_rx); end
    ur_t.delete();
    for (int c = 0; c < 100 && frames_done < f0 + 3; c++) @(negedge clk);
    n_cmp++;
    if (last_rx !== fill) begin n_err++; $display("FAIL fill_frame got %h want %h", last_rx, fill); end
    n_cmp++;
    if (ur_t.size() != 1) begin n_err++; $display("FAIL fill_underrun_pulses got %0d want 1", ur_t.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_fill_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no completion want completion");
    $fatal(1, "watchdog");
  end

endmodule
